// File: rtl/mod_down_timer_pkg.sv
// Shared definitions for the lab counters: FSM state encoding and the
// up-counter modulus from which the down-timer's default MAX is derived.
package mod_down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  // Modulus of the companion mod-13 up-counter.
  localparam int unsigned UP_MODULUS = 13;

  // Largest legal down-timer count, one below the up-counter modulus.
  localparam int unsigned DEF_MAX = UP_MODULUS - 1;

endpackage

// File: rtl/mod_down_timer_if.sv
// Control/status bundle of the down-timer. The master drives the load/start/
// pause controls; the slave (the timer) returns count and status.
interface mod_down_timer_if #(
  parameter int unsigned WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, din, start, pause,
    input  Q, tc, busy, done
  );

  modport slave (
    input  load, din, start, pause,
    output Q, tc, busy, done
  );

endinterface

// File: rtl/mod_down_timer.sv
// Loadable modulo down-counter/timer. Counts a preset down to zero, pulses tc
// on the edge that reaches zero, then either parks in DONE or reloads.
module mod_down_timer
  import mod_down_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX         = DEF_MAX,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  mod_down_timer_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rl;
  logic             tc_r;
  logic [WIDTH-1:0] din_c;

  // Presets above MAX are clamped so that Q <= rl <= MAX always holds.
  assign din_c = (bus.din > MAX_W) ? MAX_W : bus.din;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; load overrides every state and every other request.
  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.start && (q != '0)) state_nxt = RUN;
        RUN: begin
          if (bus.pause)                     state_nxt = HOLD;
          else if ((q == ONE) && !AUTO_RELOAD) state_nxt = DONE;
        end
        HOLD: if (bus.start)                   state_nxt = RUN;
        DONE: if (bus.start && (rl != '0))     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Count, reload register and terminal-count pulse. tc defaults low so it
  // can only ever last one cycle and is never raised by load or reload.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q    <= '0;
      rl   <= MAX_W;
      tc_r <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (bus.load) begin
        q  <= din_c;
        rl <= din_c;
      end else begin
        unique case (state)
          RUN: begin
            if (!bus.pause) begin
              if (q == '0) begin
                q <= rl;
              end else begin
                q    <= q - ONE;
                tc_r <= (q == ONE);
              end
            end
          end
          DONE: if (bus.start && (rl != '0)) q <= rl;
          default: ;
        endcase
      end
    end
  end

  // Status outputs.
  always_comb begin
    bus.Q    = q;
    bus.tc   = tc_r;
    bus.busy = (state == RUN) || (state == HOLD);
    bus.done = (state == DONE);
  end

endmodule

// File: tb/tb_mod_down_timer.sv
// Directed bench for mod_down_timer: one instance without auto-reload, one
// with, sharing clock and clear. Expected values are hand-computed.
module tb_mod_down_timer;

  logic clk = 1'b0;
  logic clr = 1'b1;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned row   = 0;

  mod_down_timer_if #(.WIDTH(4)) a0 ();
  mod_down_timer_if #(.WIDTH(4)) a1 ();

  mod_down_timer #(.WIDTH(4), .MAX(12), .AUTO_RELOAD(1'b0)) dut0 (
    .clk (clk),
    .clr (clr),
    .bus (a0)
  );

  mod_down_timer #(.WIDTH(4), .MAX(12), .AUTO_RELOAD(1'b1)) dut1 (
    .clk (clk),
    .clr (clr),
    .bus (a1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one vector to the non-reloading timer for one edge, then check.
  task automatic vec0(input int ld, input int d, input int st, input int pa,
                      input int eq, input int etc, input int eb, input int ed);
    row++;
    a0.load  = ld[0];
    a0.din   = d[3:0];
    a0.start = st[0];
    a0.pause = pa[0];
    tick();
    a0.load  = 1'b0;
    a0.start = 1'b0;
    a0.pause = 1'b0;
    chk($sformatf("v%0d.Q", row),    int'(a0.Q),    eq);
    chk($sformatf("v%0d.tc", row),   int'(a0.tc),   etc);
    chk($sformatf("v%0d.busy", row), int'(a0.busy), eb);
    chk($sformatf("v%0d.done", row), int'(a0.done), ed);
  endtask

  initial begin
    a0.load = 1'b0; a0.din = '0; a0.start = 1'b0; a0.pause = 1'b0;
    a1.load = 1'b0; a1.din = '0; a1.start = 1'b0; a1.pause = 1'b0;

    // Reset state while clr is held.
    #2;
    chk("rst.Q",    int'(a0.Q),    0);
    chk("rst.tc",   int'(a0.tc),   0);
    chk("rst.busy", int'(a0.busy), 0);
    chk("rst.done", int'(a0.done), 0);
    #10 clr = 1'b0;
    tick();

    //   ld din st pa   Q tc busy done
    // Basic countdown from 5, then restart from DONE.
    vec0(1, 5, 0, 0,   5, 0, 0, 0);
    vec0(0, 0, 1, 0,   5, 0, 1, 0);
    vec0(0, 0, 0, 0,   4, 0, 1, 0);
    vec0(0, 0, 0, 0,   3, 0, 1, 0);
    vec0(0, 0, 0, 0,   2, 0, 1, 0);
    vec0(0, 0, 0, 0,   1, 0, 1, 0);
    vec0(0, 0, 0, 0,   0, 1, 0, 1);
    vec0(0, 0, 0, 0,   0, 0, 0, 1);
    vec0(0, 0, 1, 0,   5, 0, 1, 0);
    vec0(0, 0, 0, 0,   4, 0, 1, 0);
    // Clamp of oversize preset; zero preset makes start a no-op.
    vec0(1, 15, 0, 0, 12, 0, 0, 0);
    vec0(1, 0, 0, 0,   0, 0, 0, 0);
    vec0(0, 0, 1, 0,   0, 0, 0, 0);
    // Pause/resume, including pause+start together while running.
    vec0(1, 6, 0, 0,   6, 0, 0, 0);
    vec0(0, 0, 1, 0,   6, 0, 1, 0);
    vec0(0, 0, 0, 0,   5, 0, 1, 0);
    vec0(0, 0, 0, 0,   4, 0, 1, 0);
    vec0(0, 0, 0, 1,   4, 0, 1, 0);
    vec0(0, 0, 0, 1,   4, 0, 1, 0);
    vec0(0, 0, 0, 1,   4, 0, 1, 0);
    vec0(0, 0, 1, 0,   4, 0, 1, 0);
    vec0(0, 0, 0, 0,   3, 0, 1, 0);
    vec0(0, 0, 1, 1,   3, 0, 1, 0);
    vec0(0, 0, 1, 0,   3, 0, 1, 0);
    vec0(0, 0, 0, 0,   2, 0, 1, 0);
    vec0(0, 0, 0, 0,   1, 0, 1, 0);
    vec0(0, 0, 0, 0,   0, 1, 0, 1);
    vec0(0, 0, 1, 0,   6, 0, 1, 0);
    // Load with start on the edge that would have produced tc.
    vec0(1, 2, 0, 0,   2, 0, 0, 0);
    vec0(0, 0, 1, 0,   2, 0, 1, 0);
    vec0(0, 0, 0, 0,   1, 0, 1, 0);
    vec0(1, 3, 1, 0,   3, 0, 0, 0);
    vec0(0, 0, 0, 1,   3, 0, 0, 0);

    // Auto-reload: period 13, tc when Q returns to 0, done never set.
    a1.load = 1'b1; a1.din = 4'd12;
    tick();
    a1.load = 1'b0;
    chk("ar.load.Q",  int'(a1.Q),  12);
    chk("ar.load.tc", int'(a1.tc), 0);
    a1.start = 1'b1;
    tick();
    a1.start = 1'b0;
    chk("ar.start.Q",    int'(a1.Q),    12);
    chk("ar.start.busy", int'(a1.busy), 1);
    for (int i = 1; i <= 39; i++) begin
      int eq;
      tick();
      eq = 12 - (i % 13);
      chk($sformatf("ar%0d.Q", i),    int'(a1.Q),    eq);
      chk($sformatf("ar%0d.tc", i),   int'(a1.tc),   (eq == 0) ? 1 : 0);
      chk($sformatf("ar%0d.done", i), int'(a1.done), 0);
      chk($sformatf("ar%0d.busy", i), int'(a1.busy), 1);
    end

    // Asynchronous clear mid-run; a1 is still cycling too.
    vec0(1, 5, 0, 0,   5, 0, 0, 0);
    vec0(0, 0, 1, 0,   5, 0, 1, 0);
    vec0(0, 0, 0, 0,   4, 0, 1, 0);
    #2 clr = 1'b1;
    #1;
    chk("aclr.Q",     int'(a0.Q),    0);
    chk("aclr.tc",    int'(a0.tc),   0);
    chk("aclr.busy",  int'(a0.busy), 0);
    chk("aclr.done",  int'(a0.done), 0);
    chk("aclr1.Q",    int'(a1.Q),    0);
    chk("aclr1.busy", int'(a1.busy), 0);
    tick();
    clr = 1'b0;
    // Back in IDLE with Q=0: start is ignored.
    vec0(0, 0, 1, 0,   0, 0, 0, 0);
    // Reload register back at MAX: a max-size preset runs normally.
    vec0(1, 12, 0, 0, 12, 0, 0, 0);
    vec0(0, 0, 1, 0,  12, 0, 1, 0);
    vec0(0, 0, 0, 0,  11, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
